jtframe_upld: RTL and testbench
===============================

// Module: jtframe_upld
// PURPOSE
//  Read-back counterpart of the ROM/NVRAM download path: serves ioctl upload reads (HPS pulls bytes) from SDRAM.
//  Maps ioctl byte addresses to SDRAM bank/word addresses with the same header/bank/byte-lane rules as the download writer.
//  Fetches 16-bit words, caches one word and stalls the HPS via ioctl_wait on a miss.
//  Sits between the ioctl interface and one jtframe_sdram programming port; used for NVRAM/hiscore save.
// PARAMETERS
//  BA1_START  ~26'd0  byte offset where bank 1 begins (all-ones = unused)
//  BA2_START  ~26'd0  byte offset where bank 2 begins
//  BA3_START  ~26'd0  byte offset where bank 3 begins
//  HEADER     0       leading header bytes; not backed by SDRAM, read as 8'hFF
//  SWAB       0       swap byte lanes within each word (bit 0 only)
//  TIMEOUT    255     max cycles waiting for sdram_dok before abort; 8-bit counter
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous reset, active low
//  uploading   in   1   upload session active
//  ioctl_addr  in   26  byte address, valid with ioctl_rd
//  ioctl_rd    in   1   one-cycle read strobe
//  ioctl_din   out  8   byte returned to HPS
//  ioctl_wait  out  1   HPS must hold off; data not yet valid
//  prog_addr   out  22  SDRAM word address [22:1]
//  prog_ba     out  2   SDRAM bank
//  prog_rd     out  1   read request, held until sdram_ack
//  sdram_ack   in   1   request accepted
//  sdram_dok   in   1   prog_din valid this cycle
//  prog_din    in   16  SDRAM read data
//  rd_err      out  1   sticky: a fetch timed out in this session
// BEHAVIOUR
//  Reset: ioctl_din=0, ioctl_wait=0, prog_addr=0, prog_ba=0, prog_rd=0, rd_err=0, cache invalid, state IDLE.
//  Address map: part=ioctl_addr-HEADER; bank = highest BAn_START <= part (bank 0 if all unused); eff=part-BAn_START.
//   Word tag = {bank, eff[22:1]}; lane = eff[0]^SWAB[0]: 1 -> prog_din[7:0], 0 -> prog_din[15:8].
//  FSM IDLE/REQ/DATA:
//   IDLE, ioctl_rd && uploading:
//    header byte (ioctl_addr<HEADER): ioctl_din<=8'hFF next cycle, no SDRAM access, wait stays 0.
//    cache hit (valid && tag match): ioctl_din<=cached lane next cycle; wait stays 0.
//    miss: ioctl_wait<=1, prog_addr/prog_ba<=tag, prog_rd<=1, go REQ.
//   REQ: hold prog_rd/prog_addr stable; on sdram_ack -> prog_rd<=0, go DATA (ack+dok same cycle: treat as DATA completion).
//   DATA: on sdram_dok: cache<=prog_din, tag stored, valid<=1, ioctl_din<=lane byte, ioctl_wait<=0, go IDLE.
//  Latency: hit/header = 1 cycle; miss = wait asserted 1 cycle after ioctl_rd, released same edge ioctl_din updates.
//  Timeout: 8-bit counter runs in REQ+DATA; reaching TIMEOUT -> prog_rd<=0, ioctl_din<=8'h00, wait<=0,
//   rd_err<=1, cache invalid, IDLE.
//  ioctl_rd while ioctl_wait=1: ignored (protocol violation; flagged by sim assertion).
//  uploading falls at any state: prog_rd<=0, ioctl_wait<=0, cache invalid, IDLE next cycle; rd_err cleared on rising uploading.
//  ioctl_rd with uploading=0: ignored, outputs unchanged.
//  Cache never invalidated by hits; odd/even byte pair of one word costs a single SDRAM read.
//  rst_n asserted mid-fetch: all outputs return to reset values immediately; pending ack/dok afterwards ignored.
// STRUCTURE
//  Shared package: bank-start sentinel (~26'd0), state encoding (IDLE/REQ/DATA), header fill byte 8'hFF.
//  Sub-module jtframe_upld_map: combinational ioctl_addr -> {header, bank, word addr, lane};
//   keep mapping bit-identical to the download path so upload/download round-trips match.
//  Top holds FSM, one-word cache and timeout counter.
// TESTING
//  HEADER=0, no banks: rd addr 0x10 -> wait=1, prog_addr=0x08, prog_rd until ack; dok prog_din=16'hA55A -> ioctl_din=8'hA5.
//  Then rd addr 0x11 -> no prog_rd, wait stays 0, ioctl_din=8'h5A next cycle; SWAB=1 rerun gives 5A then A5.
//  HEADER=64: rd addr 0x20 -> ioctl_din=8'hFF, no prog_rd; rd addr 0x40 -> prog_addr=0, prog_ba=0.
//  BA1_START=0x100000: rd addr 0x100004 -> prog_ba=1, prog_addr=0x000002.
//  No dok for 255 cycles -> ioctl_din=8'h00, wait=0, rd_err=1; next rd same addr refetches (cache invalid).
//  uploading dropped while in REQ -> prog_rd=0, wait=0 next cycle; rst_n pulse in DATA -> all outputs reset values.

Source files
------------

// File: rtl/jtframe_upld_pkg.sv
// rtl/jtframe_upld_pkg.sv - shared constants for the ioctl upload read-back path
package jtframe_upld_pkg;

    // Bank start value meaning "this bank is not used"
    localparam logic [25:0] BA_UNUSED = ~26'd0;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Value returned for header bytes, which have no SDRAM backing
    localparam logic [7:0] HDR_FILL = 8'hFF;

endpackage

// File: rtl/jtframe_upld_map.sv
// rtl/jtframe_upld_map.sv - ioctl byte address to SDRAM bank/word/lane mapping
//
// Ports:
//   addr      in  26  ioctl byte address
//   is_header out  1  address falls inside the leading header
//   bank      out  2  SDRAM bank
//   waddr     out 22  SDRAM word address (byte offset [22:1] within the bank)
//   lane      out  1  1 -> low byte of the word, 0 -> high byte
//
// Must stay bit-identical to the download writer so saved data round-trips.
module jtframe_upld_map
    import jtframe_upld_pkg::*;
#(
    parameter logic [25:0] BA1_START = BA_UNUSED,
    parameter logic [25:0] BA2_START = BA_UNUSED,
    parameter logic [25:0] BA3_START = BA_UNUSED,
    parameter int          HEADER    = 0,
    parameter int          SWAB      = 0
)(
    input  logic [25:0] addr,
    output logic        is_header,
    output logic [1:0]  bank,
    output logic [21:0] waddr,
    output logic        lane
);

    localparam logic [25:0] HDR_LEN = 26'(HEADER);
    localparam logic        SWAP    = (SWAB % 2) != 0;

    logic [25:0] part;
    logic [25:0] start;
    logic [22:0] eff;

    always_comb begin
        is_header = addr < HDR_LEN;
        part      = addr - HDR_LEN;
        // Highest used bank whose start is at or below the offset wins
        if (BA3_START != BA_UNUSED && part >= BA3_START) begin
            bank  = 2'd3;
            start = BA3_START;
        end else if (BA2_START != BA_UNUSED && part >= BA2_START) begin
            bank  = 2'd2;
            start = BA2_START;
        end else if (BA1_START != BA_UNUSED && part >= BA1_START) begin
            bank  = 2'd1;
            start = BA1_START;
        end else begin
            bank  = 2'd0;
            start = 26'd0;
        end
        eff   = 23'(part - start);
        waddr = eff[22:1];
        lane  = eff[0] ^ SWAP;
    end

endmodule

// File: rtl/jtframe_upld.sv
// rtl/jtframe_upld.sv - serves ioctl upload reads from SDRAM through a one-word cache
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   uploading             upload session active
//   ioctl_addr, ioctl_rd  byte read request from the HPS
//   ioctl_din, ioctl_wait byte returned, hold-off while a fetch is pending
//   prog_addr, prog_ba    SDRAM word address and bank
//   prog_rd               read request, held until sdram_ack
//   sdram_ack, sdram_dok  request accepted / read data valid
//   prog_din              SDRAM read data
//   rd_err                sticky fetch-timeout flag, cleared when a session starts
module jtframe_upld
    import jtframe_upld_pkg::*;
#(
    parameter logic [25:0] BA1_START = BA_UNUSED,
    parameter logic [25:0] BA2_START = BA_UNUSED,
    parameter logic [25:0] BA3_START = BA_UNUSED,
    parameter int          HEADER    = 0,
    parameter int          SWAB      = 0,
    parameter int          TIMEOUT   = 255
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uploading,
    input  logic [25:0] ioctl_addr,
    input  logic        ioctl_rd,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic [21:0] prog_addr,
    output logic [1:0]  prog_ba,
    output logic        prog_rd,
    input  logic        sdram_ack,
    input  logic        sdram_dok,
    input  logic [15:0] prog_din,
    output logic        rd_err
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic        m_hdr;
    logic [1:0]  m_bank;
    logic [21:0] m_waddr;
    logic        m_lane;

    jtframe_upld_map #(
        .BA1_START (BA1_START),
        .BA2_START (BA2_START),
        .BA3_START (BA3_START),
        .HEADER    (HEADER),
        .SWAB      (SWAB)
    ) u_map (
        .addr      (ioctl_addr),
        .is_header (m_hdr),
        .bank      (m_bank),
        .waddr     (m_waddr),
        .lane      (m_lane)
    );

    logic [1:0]  state_q, state_d;
    logic [7:0]  din_q,   din_d;
    logic        wait_q,  wait_d;
    logic [21:0] addr_q,  addr_d;
    logic [1:0]  ba_q,    ba_d;
    logic        rd_q,    rd_d;
    logic        err_q,   err_d;
    logic [15:0] cache_q, cache_d;
    logic [23:0] tag_q,   tag_d;
    logic        valid_q, valid_d;
    logic        lane_q,  lane_d;
    logic [7:0]  tmr_q,   tmr_d;
    logic        upl_q;

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        ba_d    = ba_q;
        rd_d    = rd_q;
        err_d   = err_q;
        cache_d = cache_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        lane_d  = lane_q;
        tmr_d   = tmr_q;

        if (uploading && !upl_q) err_d = 1'b0;

        if (!uploading) begin
            state_d = ST_IDLE;
            rd_d    = 1'b0;
            wait_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_REQ, ST_DATA: begin
                    tmr_d = tmr_q + 8'd1;
                    if (state_q == ST_REQ && sdram_ack) begin
                        rd_d    = 1'b0;
                        state_d = ST_DATA;
                    end
                    // Data can arrive on the ack cycle itself
                    if (sdram_dok && (state_q == ST_DATA || sdram_ack)) begin
                        cache_d = prog_din;
                        tag_d   = {ba_q, addr_q};
                        valid_d = 1'b1;
                        din_d   = lane_q ? prog_din[7:0] : prog_din[15:8];
                        wait_d  = 1'b0;
                        rd_d    = 1'b0;
                        state_d = ST_IDLE;
                    end else if (tmr_q == TMO) begin
                        rd_d    = 1'b0;
                        din_d   = 8'h00;
                        wait_d  = 1'b0;
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    if (ioctl_rd && !wait_q) begin
                        if (m_hdr) begin
                            din_d = HDR_FILL;
                        end else if (valid_q && tag_q == {m_bank, m_waddr}) begin
                            din_d = m_lane ? cache_q[7:0] : cache_q[15:8];
                        end else begin
                            wait_d  = 1'b1;
                            addr_d  = m_waddr;
                            ba_d    = m_bank;
                            rd_d    = 1'b1;
                            lane_d  = m_lane;
                            tmr_d   = 8'd0;
                            state_d = ST_REQ;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            din_q   <= 8'h00;
            wait_q  <= 1'b0;
            addr_q  <= 22'd0;
            ba_q    <= 2'd0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            cache_q <= 16'h0000;
            tag_q   <= 24'd0;
            valid_q <= 1'b0;
            lane_q  <= 1'b0;
            tmr_q   <= 8'd0;
            upl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            ba_q    <= ba_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            cache_q <= cache_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            lane_q  <= lane_d;
            tmr_q   <= tmr_d;
            upl_q   <= uploading;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign prog_addr  = addr_q;
    assign prog_ba    = ba_q;
    assign prog_rd    = rd_q;
    assign rd_err     = err_q;

`ifndef SYNTHESIS
    // The HPS must not issue a new read while held off
    rd_while_wait: assert property (@(posedge clk) disable iff (!rst_n) !(ioctl_rd && ioctl_wait));
`endif

endmodule

// File: tb/tb_jtframe_upld.sv
// tb/tb_jtframe_upld.sv - directed self-checking bench for jtframe_upld
module tb_jtframe_upld;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uploading;
    logic [25:0] ioctl_addr;
    logic        rd   [4];
    logic [7:0]  din  [4];
    logic        wt   [4];
    logic [21:0] pa   [4];
    logic [1:0]  pb   [4];
    logic        prd  [4];
    logic        err  [4];
    logic        sdram_ack;
    logic        sdram_dok;
    logic [15:0] prog_din;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // u0: plain, u1: swapped lanes, u2: 64-byte header, u3: bank 1 at 1 MiB
    jtframe_upld u0 (.clk(clk), .rst_n(rst_n), .uploading(uploading), .ioctl_addr(ioctl_addr),
        .ioctl_rd(rd[0]), .ioctl_din(din[0]), .ioctl_wait(wt[0]), .prog_addr(pa[0]), .prog_ba(pb[0]),
        .prog_rd(prd[0]), .sdram_ack(sdram_ack), .sdram_dok(sdram_dok), .prog_din(prog_din), .rd_err(err[0]));
    jtframe_upld #(.SWAB(1)) u1 (.clk(clk), .rst_n(rst_n), .uploading(uploading), .ioctl_addr(ioctl_addr),
        .ioctl_rd(rd[1]), .ioctl_din(din[1]), .ioctl_wait(wt[1]), .prog_addr(pa[1]), .prog_ba(pb[1]),
        .prog_rd(prd[1]), .sdram_ack(sdram_ack), .sdram_dok(sdram_dok), .prog_din(prog_din), .rd_err(err[1]));
    jtframe_upld #(.HEADER(64)) u2 (.clk(clk), .rst_n(rst_n), .uploading(uploading), .ioctl_addr(ioctl_addr),
        .ioctl_rd(rd[2]), .ioctl_din(din[2]), .ioctl_wait(wt[2]), .prog_addr(pa[2]), .prog_ba(pb[2]),
        .prog_rd(prd[2]), .sdram_ack(sdram_ack), .sdram_dok(sdram_dok), .prog_din(prog_din), .rd_err(err[2]));
    jtframe_upld #(.BA1_START(26'h100000)) u3 (.clk(clk), .rst_n(rst_n), .uploading(uploading), .ioctl_addr(ioctl_addr),
        .ioctl_rd(rd[3]), .ioctl_din(din[3]), .ioctl_wait(wt[3]), .prog_addr(pa[3]), .prog_ba(pb[3]),
        .prog_rd(prd[3]), .sdram_ack(sdram_ack), .sdram_dok(sdram_dok), .prog_din(prog_din), .rd_err(err[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rd(input int k, input logic [25:0] a);
        ioctl_addr = a;
        rd[k] = 1'b1;
        tick();
        rd[k] = 1'b0;
    endtask

    task automatic ack_dok(input logic [15:0] d);
        sdram_ack = 1'b1;
        sdram_dok = 1'b1;
        prog_din  = d;
        tick();
        sdram_ack = 1'b0;
        sdram_dok = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (din[0] !== 8'h00) begin n_bad++; $display("FAIL reset_din got %h want 00", din[0]); end
        n_cmp++; if (wt[0] !== 1'b0) begin n_bad++; $display("FAIL reset_wait got %b want 0", wt[0]); end
        n_cmp++; if (pa[0] !== 22'd0 || pb[0] !== 2'd0) begin n_bad++; $display("FAIL reset_addr got %h/%h want 0/0", pa[0], pb[0]); end
        n_cmp++; if (prd[0] !== 1'b0 || err[0] !== 1'b0) begin n_bad++; $display("FAIL reset_rd_err got %b%b want 00", prd[0], err[0]); end
    endtask

    task automatic test_miss();
        pulse_rd(0, 26'h10);
        n_cmp++; if (wt[0] !== 1'b1 || prd[0] !== 1'b1) begin n_bad++; $display("FAIL miss_start wait/rd got %b%b want 11", wt[0], prd[0]); end
        n_cmp++; if (pa[0] !== 22'h08 || pb[0] !== 2'd0) begin n_bad++; $display("FAIL miss_addr got %h/%h want 08/0", pa[0], pb[0]); end
        tick(); tick();
        n_cmp++; if (prd[0] !== 1'b1 || pa[0] !== 22'h08) begin n_bad++; $display("FAIL miss_hold rd/addr got %b/%h want 1/08", prd[0], pa[0]); end
        sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
        n_cmp++; if (prd[0] !== 1'b0 || wt[0] !== 1'b1) begin n_bad++; $display("FAIL miss_ack rd/wait got %b%b want 01", prd[0], wt[0]); end
        prog_din = 16'hA55A; sdram_dok = 1'b1; tick(); sdram_dok = 1'b0;
        n_cmp++; if (wt[0] !== 1'b0 || din[0] !== 8'hA5) begin n_bad++; $display("FAIL miss_data got %b/%h want 0/a5", wt[0], din[0]); end
    endtask

    task automatic test_hit();
        pulse_rd(0, 26'h11);
        n_cmp++; if (din[0] !== 8'h5A) begin n_bad++; $display("FAIL hit_din got %h want 5a", din[0]); end
        n_cmp++; if (wt[0] !== 1'b0 || prd[0] !== 1'b0) begin n_bad++; $display("FAIL hit_no_fetch wait/rd got %b%b want 00", wt[0], prd[0]); end
    endtask

    task automatic test_swab();
        pulse_rd(1, 26'h10);
        n_cmp++; if (prd[1] !== 1'b1 || pa[1] !== 22'h08) begin n_bad++; $display("FAIL swab_req rd/addr got %b/%h want 1/08", prd[1], pa[1]); end
        ack_dok(16'hA55A);
        n_cmp++; if (din[1] !== 8'h5A || wt[1] !== 1'b0) begin n_bad++; $display("FAIL swab_even got %h/%b want 5a/0", din[1], wt[1]); end
        pulse_rd(1, 26'h11);
        n_cmp++; if (din[1] !== 8'hA5 || prd[1] !== 1'b0) begin n_bad++; $display("FAIL swab_odd got %h/%b want a5/0", din[1], prd[1]); end
    endtask

    task automatic test_header();
        pulse_rd(2, 26'h20);
        n_cmp++; if (din[2] !== 8'hFF) begin n_bad++; $display("FAIL hdr_din got %h want ff", din[2]); end
        n_cmp++; if (prd[2] !== 1'b0 || wt[2] !== 1'b0) begin n_bad++; $display("FAIL hdr_no_fetch rd/wait got %b%b want 00", prd[2], wt[2]); end
        pulse_rd(2, 26'h40);
        n_cmp++; if (prd[2] !== 1'b1 || pa[2] !== 22'd0 || pb[2] !== 2'd0) begin n_bad++; $display("FAIL hdr_first got rd %b addr %h ba %h want 1/0/0", prd[2], pa[2], pb[2]); end
        ack_dok(16'h1234);
        n_cmp++; if (din[2] !== 8'h12) begin n_bad++; $display("FAIL hdr_first_data got %h want 12", din[2]); end
    endtask

    task automatic test_bank();
        pulse_rd(3, 26'h100004);
        n_cmp++; if (pb[3] !== 2'd1 || pa[3] !== 22'h000002) begin n_bad++; $display("FAIL bank1 got ba %h addr %h want 1/000002", pb[3], pa[3]); end
        ack_dok(16'hBEEF);
        n_cmp++; if (din[3] !== 8'hBE || wt[3] !== 1'b0) begin n_bad++; $display("FAIL bank1_data got %h/%b want be/0", din[3], wt[3]); end
    endtask

    task automatic test_timeout();
        int cnt;
        pulse_rd(0, 26'h30);
        n_cmp++; if (prd[0] !== 1'b1 || pa[0] !== 22'h18) begin n_bad++; $display("FAIL tmo_req rd/addr got %b/%h want 1/18", prd[0], pa[0]); end
        sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
        cnt = 1;
        while (wt[0] === 1'b1 && cnt < 400) begin
            tick();
            cnt++;
        end
        n_cmp++; if (cnt < 250 || cnt > 260) begin n_bad++; $display("FAIL tmo_cycles got %0d want 250..260", cnt); end
        n_cmp++; if (din[0] !== 8'h00 || wt[0] !== 1'b0 || err[0] !== 1'b1) begin n_bad++; $display("FAIL tmo_abort got din %h wait %b err %b want 00/0/1", din[0], wt[0], err[0]); end
        // Word 8 was cached before; the abort must have dropped it
        pulse_rd(0, 26'h11);
        n_cmp++; if (prd[0] !== 1'b1 || wt[0] !== 1'b1 || pa[0] !== 22'h08) begin n_bad++; $display("FAIL tmo_refetch got rd %b wait %b addr %h want 1/1/08", prd[0], wt[0], pa[0]); end
        ack_dok(16'h6789);
        n_cmp++; if (din[0] !== 8'h89 || err[0] !== 1'b1) begin n_bad++; $display("FAIL tmo_after got din %h err %b want 89/1", din[0], err[0]); end
    endtask

    task automatic test_upload_drop();
        pulse_rd(0, 26'h50);
        n_cmp++; if (prd[0] !== 1'b1) begin n_bad++; $display("FAIL drop_req got %b want 1", prd[0]); end
        uploading = 1'b0; tick();
        n_cmp++; if (prd[0] !== 1'b0 || wt[0] !== 1'b0) begin n_bad++; $display("FAIL drop_abort rd/wait got %b%b want 00", prd[0], wt[0]); end
        uploading = 1'b1; tick();
        n_cmp++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL drop_err_clear got %b want 0", err[0]); end
        pulse_rd(0, 26'h11);
        n_cmp++; if (prd[0] !== 1'b1) begin n_bad++; $display("FAIL drop_cache_inval got %b want 1", prd[0]); end
        ack_dok(16'h7788);
        n_cmp++; if (din[0] !== 8'h88) begin n_bad++; $display("FAIL drop_refill got %h want 88", din[0]); end
    endtask

    task automatic test_reset_mid();
        pulse_rd(0, 26'h60);
        sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
        n_cmp++; if (wt[0] !== 1'b1 || pa[0] !== 22'h30) begin n_bad++; $display("FAIL rst_pre wait/addr got %b/%h want 1/30", wt[0], pa[0]); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (din[0] !== 8'h00 || wt[0] !== 1'b0 || prd[0] !== 1'b0) begin n_bad++; $display("FAIL rst_async got din %h wait %b rd %b want 00/0/0", din[0], wt[0], prd[0]); end
        n_cmp++; if (pa[0] !== 22'd0 || pb[0] !== 2'd0 || err[0] !== 1'b0) begin n_bad++; $display("FAIL rst_async_addr got %h/%h/%b want 0/0/0", pa[0], pb[0], err[0]); end
        tick();
        rst_n = 1'b1;
        prog_din = 16'hFFFF; sdram_dok = 1'b1; sdram_ack = 1'b1; tick(); sdram_dok = 1'b0; sdram_ack = 1'b0;
        n_cmp++; if (din[0] !== 8'h00 || wt[0] !== 1'b0) begin n_bad++; $display("FAIL rst_stale_dok got %h/%b want 00/0", din[0], wt[0]); end
        pulse_rd(0, 26'h11);
        n_cmp++; if (prd[0] !== 1'b1) begin n_bad++; $display("FAIL rst_cache_inval got %b want 1", prd[0]); end
        ack_dok(16'h0102);
        n_cmp++; if (din[0] !== 8'h02) begin n_bad++; $display("FAIL rst_refill got %h want 02", din[0]); end
    endtask

    initial begin
        rst_n      = 1'b0;
        uploading  = 1'b0;
        ioctl_addr = 26'd0;
        sdram_ack  = 1'b0;
        sdram_dok  = 1'b0;
        prog_din   = 16'h0000;
        for (int i = 0; i < 4; i++) rd[i] = 1'b0;
        tick(); tick();
        test_reset();
        rst_n     = 1'b1;
        uploading = 1'b1;
        tick();
        test_miss();
        test_hit();
        test_swab();
        test_header();
        test_bank();
        test_timeout();
        test_upload_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
